// File: rtl/cmd_parser_pkg.sv
// Shared command ICD package for the command parser.
// Holds the command id enum, the bit positions of every command field,
// and builder functions that assemble well-formed command words.
package cmd_parser_pkg;

  typedef enum logic [3:0] {
    CMD_BANK = 4'h0,
    CMD_OUT  = 4'h1
  } cmd_id_t;

  localparam int ID_MSB         = 31;
  localparam int ID_LSB         = 28;

  localparam int BANK_EN_MSB    = 3;
  localparam int BANK_EN_LSB    = 0;
  localparam int BANK_RSVD0_MSB = 7;
  localparam int BANK_RSVD0_LSB = 4;
  localparam int BANK_VAL_MSB   = 15;
  localparam int BANK_VAL_LSB   = 8;
  localparam int BANK_RSVD1_MSB = 27;
  localparam int BANK_RSVD1_LSB = 16;

  localparam int OUT_SEL_MSB    = 4;
  localparam int OUT_SEL_LSB    = 0;
  localparam int OUT_RSVD_MSB   = 27;
  localparam int OUT_RSVD_LSB   = 5;

  function automatic logic [31:0] build_bank(input logic [3:0] en, input logic [7:0] val);
    logic [31:0] w;
    w = '0;
    w[ID_MSB:ID_LSB]             = CMD_BANK;
    w[BANK_EN_MSB:BANK_EN_LSB]   = en;
    w[BANK_VAL_MSB:BANK_VAL_LSB] = val;
    return w;
  endfunction

  function automatic logic [31:0] build_out(input logic [4:0] sel);
    logic [31:0] w;
    w = '0;
    w[ID_MSB:ID_LSB]           = CMD_OUT;
    w[OUT_SEL_MSB:OUT_SEL_LSB] = sel;
    return w;
  endfunction

endpackage

// File: rtl/cmd_parser_if.sv
// Command word handshake bundle.
//   cmd_valid : command word present (master -> slave)
//   cmd_data  : 32-bit command word   (master -> slave)
//   cmd_ready : slave can accept       (slave -> master)
interface cmd_parser_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;

  modport master (output cmd_valid, output cmd_data, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_data, output cmd_ready);
endinterface

// File: rtl/cmd_lsb_sel.sv
// Lowest-set-bit finder for the 4-bit pending bank mask.
//   mask_i : pending mask
//   idx_o  : index of the lowest set bit (0 when the mask is empty)
module cmd_lsb_sel (
  input  logic [3:0] mask_i,
  output logic [1:0] idx_o
);
  always_comb begin
    idx_o = 2'd0;
    if      (mask_i[0]) idx_o = 2'd0;
    else if (mask_i[1]) idx_o = 2'd1;
    else if (mask_i[2]) idx_o = 2'd2;
    else if (mask_i[3]) idx_o = 2'd3;
  end
endmodule

// File: rtl/cmd_parser.sv
// Command parser: accepts 32-bit command words and turns them into bank
// register writes, output-select updates or error pulses.
//   clk, rst     : clock, asynchronous active-high reset
//   cmd          : command handshake (slave side)
//   bank_wr_*    : one bank register write per cycle while a BANK command drains
//   out_sel/stb  : output selection and its one-cycle update pulse
//   err_stb      : one-cycle pulse per rejected command
//   err_count    : saturating rejected-command count
//   cmd_count    : wrapping accepted, well-formed command count
module cmd_parser
  import cmd_parser_pkg::*;
#(
  parameter int ERR_CNT_W = 8,
  parameter int CMD_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  cmd_parser_if.slave          cmd,
  output logic                 bank_wr_en,
  output logic [1:0]           bank_wr_idx,
  output logic [7:0]           bank_wr_data,
  output logic [4:0]           out_sel,
  output logic                 out_stb,
  output logic                 err_stb,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [CMD_CNT_W-1:0] cmd_count
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] BANK_WR = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [3:0]           mask_q, mask_d;
  logic                 wr_en_q, wr_en_d;
  logic [1:0]           wr_idx_q, wr_idx_d;
  logic [7:0]           wr_data_q, wr_data_d;
  logic [4:0]           out_sel_q, out_sel_d;
  logic                 out_stb_q, out_stb_d;
  logic                 err_stb_q, err_stb_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CMD_CNT_W-1:0] cmd_cnt_q, cmd_cnt_d;

  logic       accept;
  logic       is_bank;
  logic       is_out;
  logic [3:0] en_f;
  logic [3:0] cleared;
  logic [3:0] lsb_in;
  logic [1:0] lsb_idx;

  assign cmd.cmd_ready = (state_q == IDLE);
  assign accept        = cmd.cmd_valid && (state_q == IDLE);

  assign en_f    = cmd.cmd_data[BANK_EN_MSB:BANK_EN_LSB];
  assign is_bank = (cmd.cmd_data[ID_MSB:ID_LSB] == CMD_BANK)
                && (cmd.cmd_data[BANK_RSVD0_MSB:BANK_RSVD0_LSB] == '0)
                && (cmd.cmd_data[BANK_RSVD1_MSB:BANK_RSVD1_LSB] == '0);
  assign is_out  = (cmd.cmd_data[ID_MSB:ID_LSB] == CMD_OUT)
                && (cmd.cmd_data[OUT_RSVD_MSB:OUT_RSVD_LSB] == '0);

  // Mask left after retiring the bit being written this cycle.
  assign cleared = mask_q & ~(4'b0001 << wr_idx_q);

  // The index register always holds the bit to write in the coming cycle,
  // so the finder looks at the mask that will be pending after this edge.
  assign lsb_in = (state_q == IDLE) ? en_f : cleared;

  cmd_lsb_sel u_lsb_sel (
    .mask_i (lsb_in),
    .idx_o  (lsb_idx)
  );

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    wr_en_d   = wr_en_q;
    wr_idx_d  = wr_idx_q;
    wr_data_d = wr_data_q;
    out_sel_d = out_sel_q;
    out_stb_d = 1'b0;
    err_stb_d = 1'b0;
    err_cnt_d = err_cnt_q;
    cmd_cnt_d = cmd_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_bank) begin
            cmd_cnt_d = cmd_cnt_q + 1'b1;
            // An empty enable mask is a legal no-op.
            if (en_f != 4'd0) begin
              state_d   = BANK_WR;
              mask_d    = en_f;
              wr_en_d   = 1'b1;
              wr_idx_d  = lsb_idx;
              wr_data_d = cmd.cmd_data[BANK_VAL_MSB:BANK_VAL_LSB];
            end
          end else if (is_out) begin
            cmd_cnt_d = cmd_cnt_q + 1'b1;
            out_sel_d = cmd.cmd_data[OUT_SEL_MSB:OUT_SEL_LSB];
            out_stb_d = 1'b1;
          end else begin
            err_stb_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
          end
        end
      end
      BANK_WR: begin
        mask_d = cleared;
        if (cleared == 4'd0) begin
          state_d = IDLE;
          wr_en_d = 1'b0;
        end else begin
          wr_idx_d = lsb_idx;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mask_q    <= 4'd0;
      wr_en_q   <= 1'b0;
      out_sel_q <= 5'd0;
      out_stb_q <= 1'b0;
      err_stb_q <= 1'b0;
      err_cnt_q <= '0;
      cmd_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      wr_en_q   <= wr_en_d;
      out_sel_q <= out_sel_d;
      out_stb_q <= out_stb_d;
      err_stb_q <= err_stb_d;
      err_cnt_q <= err_cnt_d;
      cmd_cnt_q <= cmd_cnt_d;
    end
  end

  // Write index/data are qualified by bank_wr_en and need no reset.
  always_ff @(posedge clk) begin
    wr_idx_q  <= wr_idx_d;
    wr_data_q <= wr_data_d;
  end

  assign bank_wr_en   = wr_en_q;
  assign bank_wr_idx  = wr_idx_q;
  assign bank_wr_data = wr_data_q;
  assign out_sel      = out_sel_q;
  assign out_stb      = out_stb_q;
  assign err_stb      = err_stb_q;
  assign err_count    = err_cnt_q;
  assign cmd_count    = cmd_cnt_q;

endmodule

// File: tb/tb_cmd_parser.sv
// Self-checking bench for cmd_parser: a queue-based behavioural model is
// compared against the DUT every cycle, plus literal checks per scenario.
module tb_cmd_parser;
  localparam int ERR_W = 8;
  localparam int CMD_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             bank_wr_en;
  logic [1:0]       bank_wr_idx;
  logic [7:0]       bank_wr_data;
  logic [4:0]       out_sel;
  logic             out_stb;
  logic             err_stb;
  logic [ERR_W-1:0] err_count;
  logic [CMD_W-1:0] cmd_count;

  cmd_parser_if cif();

  cmd_parser #(.ERR_CNT_W(ERR_W), .CMD_CNT_W(CMD_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd          (cif),
    .bank_wr_en   (bank_wr_en),
    .bank_wr_idx  (bank_wr_idx),
    .bank_wr_data (bank_wr_data),
    .out_sel      (out_sel),
    .out_stb      (out_stb),
    .err_stb      (err_stb),
    .err_count    (err_count),
    .cmd_count    (cmd_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: a BANK command expands into a list of writes, one
  // per set enable bit in ascending order, shown one per cycle after
  // acceptance; the parser is ready only while no write is being shown.
  logic [9:0]  wq[$];
  logic        m_wr_en;
  logic [1:0]  m_idx;
  logic [7:0]  m_data;
  logic [4:0]  m_out;
  logic        m_out_stb;
  logic        m_err_stb;
  int          m_err;
  int          m_cmd;
  logic [31:0] md;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wq.delete();
      m_wr_en   = 1'b0;
      m_out     = 5'd0;
      m_out_stb = 1'b0;
      m_err_stb = 1'b0;
      m_err     = 0;
      m_cmd     = 0;
    end else begin
      m_out_stb = 1'b0;
      m_err_stb = 1'b0;
      if (cif.cmd_valid === 1'b1 && !m_wr_en) begin
        md = cif.cmd_data;
        if (md[31:28] == 4'h0 && md[7:4] == 4'h0 && md[27:16] == 12'h0) begin
          m_cmd = (m_cmd + 1) % (1 << CMD_W);
          for (int b = 0; b < 4; b++)
            if (md[b]) wq.push_back({2'(b), md[15:8]});
        end else if (md[31:28] == 4'h1 && md[27:5] == 23'h0) begin
          m_cmd     = (m_cmd + 1) % (1 << CMD_W);
          m_out     = md[4:0];
          m_out_stb = 1'b1;
        end else begin
          m_err_stb = 1'b1;
          if (m_err < (1 << ERR_W) - 1) m_err++;
        end
      end
      if (wq.size() > 0) begin
        {m_idx, m_data} = wq.pop_front();
        m_wr_en = 1'b1;
      end else begin
        m_wr_en = 1'b0;
      end
    end
  end

  // Observation log used by the literal scenario checks.
  logic [1:0] w_idx[$];
  logic [7:0] w_dat[$];
  int         w_cyc[$];
  int         n_out = 0;
  int         n_estb = 0;
  int         n_busy = 0;
  int         last_out_cyc = -1;

  always @(negedge clk) begin
    if (!rst) begin
      check("cmd_ready", 32'(cif.cmd_ready), 32'(!m_wr_en));
      check("bank_wr_en", 32'(bank_wr_en), 32'(m_wr_en));
      if (m_wr_en) begin
        check("bank_wr_idx", 32'(bank_wr_idx), 32'(m_idx));
        check("bank_wr_data", 32'(bank_wr_data), 32'(m_data));
      end
      check("out_sel", 32'(out_sel), 32'(m_out));
      check("out_stb", 32'(out_stb), 32'(m_out_stb));
      check("err_stb", 32'(err_stb), 32'(m_err_stb));
      check("err_count", 32'(err_count), 32'(m_err));
      check("cmd_count", 32'(cmd_count), 32'(m_cmd));
      if (bank_wr_en === 1'b1) begin
        w_idx.push_back(bank_wr_idx);
        w_dat.push_back(bank_wr_data);
        w_cyc.push_back(cyc);
      end
      if (out_stb === 1'b1) begin
        n_out++;
        last_out_cyc = cyc;
      end
      if (err_stb === 1'b1) n_estb++;
      if (cif.cmd_ready === 1'b0) n_busy++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a word until it is accepted; acc is the cycle number of the
  // accepting edge, which is also the number of the cycle that follows it.
  task automatic send(input logic [31:0] w, output int acc);
    logic r;
    acc = -1;
    cif.cmd_valid = 1'b1;
    cif.cmd_data  = w;
    for (int k = 0; k < 20; k++) begin
      r = cif.cmd_ready;
      @(posedge clk);
      #1;
      if (r === 1'b1) begin
        acc = cyc;
        break;
      end
    end
    cif.cmd_valid = 1'b0;
    if (acc < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: word %h not accepted, required within 20 cycles", w);
    end
  endtask

  int acc, acc2, w0, b0, o0, e0;

  initial begin
    cif.cmd_valid = 1'b0;
    cif.cmd_data  = 32'h0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_ready", 32'(cif.cmd_ready), 32'd1);
    check("rst_wr_en", 32'(bank_wr_en), 32'd0);
    check("rst_out_sel", 32'(out_sel), 32'd0);
    check("rst_strobes", {30'd0, out_stb, err_stb}, 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_cmd_count", 32'(cmd_count), 32'd0);
    idle(2);

    // BANK en=1010 val=A5: writes idx1 then idx3.
    w0 = w_idx.size(); b0 = n_busy;
    send(32'h0000_A50A, acc);
    idle(4);
    check("bank_nwrites", 32'(w_idx.size() - w0), 32'd2);
    check("bank_w0_idx", 32'(w_idx[w0]), 32'd1);
    check("bank_w0_data", 32'(w_dat[w0]), 32'hA5);
    check("bank_w0_cyc", 32'(w_cyc[w0]), 32'(acc));
    check("bank_w1_idx", 32'(w_idx[w0+1]), 32'd3);
    check("bank_w1_data", 32'(w_dat[w0+1]), 32'hA5);
    check("bank_w1_cyc", 32'(w_cyc[w0+1]), 32'(acc + 1));
    check("bank_busy", 32'(n_busy - b0), 32'd2);
    check("bank_cmd_count", 32'(cmd_count), 32'd1);

    // OUT sel=13.
    o0 = n_out; b0 = n_busy;
    send(32'h1000_0013, acc);
    idle(3);
    check("out_sel_val", 32'(out_sel), 32'h13);
    check("out_npulse", 32'(n_out - o0), 32'd1);
    check("out_pulse_cyc", 32'(last_out_cyc), 32'(acc));
    check("out_busy", 32'(n_busy - b0), 32'd0);

    // Unknown id, then BANK with nonzero rsvd0, back to back.
    e0 = n_estb; w0 = w_idx.size();
    send(32'h2000_0000, acc);
    send(32'h0000_0011, acc2);
    idle(3);
    check("rej_b2b_accept", 32'(acc2 - acc), 32'd1);
    check("rej_npulse", 32'(n_estb - e0), 32'd2);
    check("rej_err_count", 32'(err_count), 32'd2);
    check("rej_nwrites", 32'(w_idx.size() - w0), 32'd0);
    check("rej_cmd_count", 32'(cmd_count), 32'd2);

    // BANK no-op (en=0) then OUT sel=1 on consecutive cycles.
    w0 = w_idx.size(); o0 = n_out;
    send(32'h0000_7700, acc);
    send(32'h1000_0001, acc2);
    idle(3);
    check("noop_b2b_accept", 32'(acc2 - acc), 32'd1);
    check("noop_nwrites", 32'(w_idx.size() - w0), 32'd0);
    check("noop_cmd_count", 32'(cmd_count), 32'd4);
    check("noop_out_sel", 32'(out_sel), 32'd1);
    check("noop_out_npulse", 32'(n_out - o0), 32'd1);

    // 300 rejected words back to back: counter saturates at 255.
    e0 = n_estb;
    for (int i = 0; i < 300; i++) begin
      case (i % 3)
        0:       send(32'h2000_0000 | 32'(i), acc);
        1:       send(32'h0000_0010, acc);
        default: send(32'h1000_0020, acc);
      endcase
    end
    idle(3);
    check("sat_err_count", 32'(err_count), 32'd255);
    check("sat_npulse", 32'(n_estb - e0), 32'd300);
    check("sat_cmd_count", 32'(cmd_count), 32'd4);

    // BANK en=1111 val=FF, reset during the second write.
    w0 = w_idx.size();
    send(32'h0000_FF0F, acc);
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("abort_ready", 32'(cif.cmd_ready), 32'd1);
    check("abort_wr_en", 32'(bank_wr_en), 32'd0);
    check("abort_err_count", 32'(err_count), 32'd0);
    check("abort_cmd_count", 32'(cmd_count), 32'd0);
    check("abort_out_sel", 32'(out_sel), 32'd0);
    idle(6);
    check("abort_nwrites", 32'(w_idx.size() - w0), 32'd2);
    check("abort_w1_idx", 32'(w_idx[w0+1]), 32'd1);
    check("abort_w1_data", 32'(w_dat[w0+1]), 32'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
